pokey_access_sequencer: RTL and testbench

// Bus master and arbiter for one POKEY instance. Generates phi2 from clk and initialises POKEY after reset
// (SKCTL/AUDF/AUDC/AUDCTL). Then shares POKEY's register port round-robin between two requesters, e.g.

---
 rtl/pokey_access_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_pokey_access_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pokey_access_sequencer
// Purpose  : Bus master and two-way round-robin arbiter for one POKEY chip.
//            Generates phi2 from clk. After reset it runs an 11-period init
//            sequence that writes SKCTL, AUDF/AUDC and AUDCTL. It then shares
//            the POKEY register port between two requesters. Each access
//            occupies exactly one phi2 period. Every access, read or write,
//            ends with a one-cycle response strobe.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   system clock (single domain)
//   clrBar            in   asynchronous active-low reset
//   req_valid[1:0]    in   per-requester command valid
//   req_ready[1:0]    out  per-requester accept strobe (valid & ready = taken)
//   req_rw0/1         in   1 = read, 0 = write
//   req_addr0/1[3:0]  in   POKEY register address
//   req_wdata0/1[7:0] in   write data
//   rsp_valid         out  one-cycle completion strobe
//   rsp_id            out  requester that owned the completed access
//   rsp_rdata[7:0]    out  read data, 8'h00 for writes
//   init_done         out  init sequence complete, sticky until reset
//   phi2              out  POKEY phi2 clock
//   A[3:0]            out  POKEY address
//   Din[7:0]          out  POKEY write data
//   readHighWriteLow  out  POKEY R/W
//   cs0Bar            out  POKEY chip select, active-low
//   Dout[7:0]         in   POKEY read data
// ============================================================================
module pokey_access_sequencer #(
  parameter int unsigned PHI2_DIV   = 56,
  parameter logic [7:0]  INIT_SKCTL = 8'h03
) (
  input  logic       clk,
  input  logic       clrBar,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic       req_rw0,
  input  logic       req_rw1,
  input  logic [3:0] req_addr0,
  input  logic [3:0] req_addr1,
  input  logic [7:0] req_wdata0,
  input  logic [7:0] req_wdata1,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_rdata,
  output logic       init_done,
  output logic       phi2,
  output logic [3:0] A,
  output logic [7:0] Din,
  output logic       readHighWriteLow,
  output logic       cs0Bar,
  input  logic [7:0] Dout
);

  localparam int unsigned    CW        = $clog2(PHI2_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(PHI2_DIV - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(PHI2_DIV / 2);
  localparam logic [3:0]     INIT_LAST = 4'd10;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUS  = 2'd2
  } state_t;

  // Init step table: 0 and 1 hit SKCTL, 2..9 clear AUDF/AUDC 0..7,
  // 10 clears AUDCTL.
  function automatic logic [3:0] init_addr(input logic [3:0] idx);
    logic [3:0] a;
    if (idx <= 4'd1)      a = 4'hF;
    else if (idx <= 4'd9) a = idx - 4'd2;
    else                  a = 4'h8;
    return a;
  endfunction

  function automatic logic [7:0] init_data(input logic [3:0] idx);
    return (idx == 4'd1) ? INIT_SKCTL : 8'h00;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          phi2_q,      phi2_d;
  state_t        state_q,     state_d;
  logic [3:0]    init_idx_q,  init_idx_d;
  logic          start_q,     start_d;
  logic          init_done_q, init_done_d;
  logic          prio_q,      prio_d;     // requester favoured on a tie
  logic          cur_id_q,    cur_id_d;   // owner of the access on the bus
  logic          cur_rw_q,    cur_rw_d;
  logic [3:0]    a_q,         a_d;
  logic [7:0]    din_q,       din_d;
  logic          rw_q,        rw_d;
  logic          cs_n_q,      cs_n_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q,    rsp_id_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;

  logic          period_end;
  logic          win;
  logic [1:0]    grant;

  assign period_end = (cnt_q == CNT_LAST);

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d       = period_end ? '0 : cnt_q + 1'b1;
    // Registered from the next count so phi2 is high exactly while
    // cnt >= PHI2_DIV/2.
    phi2_d      = (cnt_d >= CNT_HALF);
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    start_d     = 1'b0;
    init_done_d = init_done_q;
    prio_d      = prio_q;
    cur_id_d    = cur_id_q;
    cur_rw_d    = cur_rw_q;
    a_d         = a_q;
    din_d       = din_q;
    rw_d        = rw_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    grant       = 2'b00;
    win         = 1'b0;

    // The first init period begins at the cnt==0 straight out of reset,
    // before any period boundary has occurred, so it is loaded here.
    if (start_q) begin
      a_d    = init_addr(4'd0);
      din_d  = init_data(4'd0);
      rw_d   = 1'b0;
      cs_n_d = 1'b0;
    end

    // All bus decisions are made on the last cycle of a period so that the
    // registered bus signals change exactly at the next cnt==0.
    if (period_end) begin
      unique case (state_q)
        ST_INIT: begin
          if (init_idx_q == INIT_LAST) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
            cs_n_d      = 1'b1;
            rw_d        = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 4'd1;
            a_d        = init_addr(init_idx_q + 4'd1);
            din_d      = init_data(init_idx_q + 4'd1);
            rw_d       = 1'b0;
            cs_n_d     = 1'b0;
          end
        end

        ST_IDLE, ST_BUS: begin
          // Complete the access that is finishing this cycle. POKEY has been
          // driving Dout since the phi2 rise, so it is sampled now.
          if (state_q == ST_BUS) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = cur_id_q;
            rsp_rdata_d = cur_rw_q ? Dout : 8'h00;
          end

          if (req_valid == 2'b11) win = prio_q;
          else                    win = req_valid[1];

          if (init_done_q && (req_valid != 2'b00)) begin
            grant    = win ? 2'b10 : 2'b01;
            prio_d   = ~win;
            cur_id_d = win;
            cur_rw_d = win ? req_rw1    : req_rw0;
            a_d      = win ? req_addr1  : req_addr0;
            din_d    = win ? req_wdata1 : req_wdata0;
            rw_d     = win ? req_rw1    : req_rw0;
            cs_n_d   = 1'b0;
            state_d  = ST_BUS;
          end else begin
            // Idle period: deselect, A/Din keep their last values.
            cs_n_d  = 1'b1;
            rw_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_INIT;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      cnt_q       <= '0;
      phi2_q      <= 1'b0;
      state_q     <= ST_INIT;
      init_idx_q  <= 4'd0;
      start_q     <= 1'b1;
      init_done_q <= 1'b0;
      prio_q      <= 1'b0;
      cur_id_q    <= 1'b0;
      cur_rw_q    <= 1'b0;
      a_q         <= 4'h0;
      din_q       <= 8'h00;
      rw_q        <= 1'b1;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      phi2_q      <= phi2_d;
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      start_q     <= start_d;
      init_done_q <= init_done_d;
      prio_q      <= prio_d;
      cur_id_q    <= cur_id_d;
      cur_rw_q    <= cur_rw_d;
      a_q         <= a_d;
      din_q       <= din_d;
      rw_q        <= rw_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Ready is combinational so a requester that drops valid before the grant
  // cycle is never accepted.
  assign req_ready        = grant;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_id           = rsp_id_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign init_done        = init_done_q;
  assign phi2             = phi2_q;
  assign A                = a_q;
  assign Din              = din_q;
  assign readHighWriteLow = rw_q;
  assign cs0Bar           = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_pokey_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pokey_access_sequencer
// Purpose  : Self-checking bench for pokey_access_sequencer. A driver issues
//            random and directed commands. A monitor predicts grants, bus
//            contents and responses from the timing rules and compares them
//            against the design through queues.
// Revision : 1.0  initial release
// ============================================================================
module tb_pokey_access_sequencer;

  localparam int DIV      = 56;
  localparam int INIT_END = 11 * DIV;

  logic       clk;
  logic       clrBar;
  logic [1:0] vld;
  logic [1:0] req_ready;
  logic       c_rw [2];
  logic [3:0] c_a  [2];
  logic [7:0] c_d  [2];
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       phi2;
  logic [3:0] A;
  logic [7:0] Din;
  logic       readHighWriteLow;
  logic       cs0Bar;
  logic [7:0] Dout;

  logic [7:0] pokey_rd [16];
  logic [3:0] init_a   [11];
  logic [7:0] init_d   [11];

  int   cyc;
  int   checks = 0;
  int   errors = 0;
  int   dir_ok = 0;
  logic done   = 1'b0;
  logic [1:0] took;

  typedef struct {
    logic       id;
    logic [7:0] rdata;
    int         due;
  } rsp_t;

  typedef struct {
    logic       rw;
    logic [3:0] a;
    logic [7:0] d;
    int         at;
  } bus_t;

  rsp_t rq[$];
  bus_t bq[$];

  pokey_access_sequencer #(.PHI2_DIV(DIV), .INIT_SKCTL(8'h03)) dut (
    .clk              (clk),
    .clrBar           (clrBar),
    .req_valid        (vld),
    .req_ready        (req_ready),
    .req_rw0          (c_rw[0]),
    .req_rw1          (c_rw[1]),
    .req_addr0        (c_a[0]),
    .req_addr1        (c_a[1]),
    .req_wdata0       (c_d[0]),
    .req_wdata1       (c_d[1]),
    .rsp_valid        (rsp_valid),
    .rsp_id           (rsp_id),
    .rsp_rdata        (rsp_rdata),
    .init_done        (init_done),
    .phi2             (phi2),
    .A                (A),
    .Din              (Din),
    .readHighWriteLow (readHighWriteLow),
    .cs0Bar           (cs0Bar),
    .Dout             (Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // POKEY read model: data is only meaningful while selected in a read and
  // after the phi2 rise; otherwise it drives junk.
  always_comb Dout = (!cs0Bar && readHighWriteLow && phi2) ? pokey_rd[A] : 8'hEE;

  // Cycles since reset release; equals the design's phase count mod DIV.
  always @(posedge clk or negedge clrBar) begin
    if (!clrBar) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    for (int i = 0; i < 16; i++) pokey_rd[i] = 8'($urandom);
    pokey_rd[10] = 8'h5C;
    init_a = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    init_d = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic last_g     = 1'b1;   // last granted requester; 1 means 0 is favoured
  logic rst_seen   = 1'b0;
  logic first_run  = 1'b1;   // first grant of the first run not yet seen
  logic first_wait = 1'b1;

  always @(negedge clk) begin : monitor
    int   m;
    int   ph;
    int   k;
    logic [1:0] exp_rdy;
    rsp_t r;
    bus_t b;
    #1;
    if (!clrBar) begin
      if (!rst_seen) begin
        chk("rst_cs0Bar", cs0Bar, 1);
        chk("rst_phi2", phi2, 0);
        chk("rst_rw", readHighWriteLow, 1);
        chk("rst_A", A, 0);
        chk("rst_Din", Din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", req_ready, 0);
      end
      rst_seen   = 1'b1;
      rq.delete();
      bq.delete();
      last_g     = 1'b1;
      first_wait = 1'b1;
    end else begin
      rst_seen = 1'b0;
      m  = cyc;
      ph = m % DIV;

      chk("phi2", phi2, (ph >= DIV / 2) ? 1 : 0);
      chk("init_done", init_done, (m >= INIT_END) ? 1 : 0);

      // Arbitration prediction: only on the last phase, only after init.
      exp_rdy = 2'b00;
      if (ph == DIV - 1 && m >= INIT_END) begin
        if (vld == 2'b11) exp_rdy = last_g ? 2'b01 : 2'b10;
        else              exp_rdy = vld;
      end
      chk("req_ready", req_ready, exp_rdy);

      for (int i = 0; i < 2; i++) begin
        if (vld[i] && req_ready[i]) begin
          if (first_wait && first_run) begin
            chk("first_grant_cycle", m, INIT_END + DIV - 1);
            first_run = 1'b0;
          end
          first_wait = 1'b0;
          r.id    = 1'(i);
          r.rdata = c_rw[i] ? pokey_rd[c_a[i]] : 8'h00;
          r.due   = m + DIV + 1;
          rq.push_back(r);
          b.rw = c_rw[i];
          b.a  = c_a[i];
          b.d  = c_d[i];
          b.at = m + 1 + DIV / 2;
          bq.push_back(b);
          last_g = 1'(i);
        end
      end

      if (rsp_valid) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("rsp_id", rsp_id, r.id);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_cycle", m, r.due);
        end
      end else if (rq.size() != 0 && rq[0].due <= m) begin
        chk("rsp_missing", 0, 1);
        void'(rq.pop_front());
      end

      // Bus contents at the phi2 rise, where POKEY samples.
      if (ph == DIV / 2) begin
        if (m < INIT_END) begin
          k = m / DIV;
          chk("init_cs0Bar", cs0Bar, 0);
          chk("init_rw", readHighWriteLow, 0);
          chk("init_A", A, init_a[k]);
          chk("init_Din", Din, init_d[k]);
        end else if (bq.size() != 0 && bq[0].at == m) begin
          b = bq.pop_front();
          chk("bus_cs0Bar", cs0Bar, 0);
          chk("bus_rw", readHighWriteLow, b.rw);
          chk("bus_A", A, b.a);
          if (!b.rw) chk("bus_Din", Din, b.d);
        end else begin
          chk("idle_cs0Bar", cs0Bar, 1);
          chk("idle_rw", readHighWriteLow, 1);
        end
      end

      if (done) begin
        chk("directed_grants", dir_ok, 3);
        chk("rsp_queue_drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  // mode 0: both requesters always valid; mode 1: random valid with drops;
  // mode 2: no new commands, pending ones stay until taken.
  task automatic drive_cycle(input int mode);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (mode == 2) begin
        if (took[i]) vld[i] = 1'b0;
      end else if (took[i] || !vld[i]) begin
        c_rw[i] = 1'($urandom_range(0, 1));
        c_a[i]  = 4'($urandom_range(0, 15));
        c_d[i]  = 8'($urandom);
        vld[i]  = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      end else if (mode == 1 && $urandom_range(0, 40) == 0) begin
        vld[i] = 1'b0;
      end
    end
    #2;
    took = vld & req_ready;
  endtask

  task automatic do_cmd(input int i, input logic rw, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    c_rw[i] = rw;
    c_a[i]  = a;
    c_d[i]  = d;
    vld[i]  = 1'b1;
    #2;
    took = vld & req_ready;
    for (int n = 0; n < 200 && !took[i]; n++) drive_cycle(2);
    if (took[i]) dir_ok++;
  endtask

  initial begin : driver
    clrBar = 1'b0;
    vld    = 2'b00;
    took   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      c_rw[i] = 1'b0;
      c_a[i]  = 4'h0;
      c_d[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    clrBar = 1'b1;

    repeat (1800) drive_cycle(0);
    repeat (3000) drive_cycle(1);
    repeat (200)  drive_cycle(2);

    do_cmd(1, 1'b1, 4'hA, 8'h00);
    repeat (80) drive_cycle(2);
    do_cmd(0, 1'b0, 4'h1, 8'hA5);
    repeat (80) drive_cycle(2);

    // Reset in the middle of a write access (phase 20 of its period).
    do_cmd(0, 1'b0, 4'h1, 8'h3C);
    @(negedge clk);
    vld  = 2'b00;
    took = 2'b00;
    repeat (20) @(negedge clk);
    clrBar = 1'b0;
    repeat (3) @(negedge clk);
    clrBar = 1'b1;

    repeat (700) drive_cycle(2);
    done = 1'b1;
  end

endmodule
`default_nettype wire
